// File: rtl/reg_to_mem_bridge.sv
// Replays single-beat register-bus requests onto a req/gnt/rvalid memory port,
// one transaction at a time, with a timeout that forces an error response.
module reg_to_mem_bridge #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic                   reg_ready_o,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,

  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_strb_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned CntLastInt = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

  localparam logic [CntWidth-1:0]  CNT_LAST        = CntWidth'(CntLastInt);
  localparam logic [AddrWidth-1:0] ADDR_ALIGN_MASK = ~AddrWidth'(StrbWidth - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic                stale_q;
  logic [CntWidth-1:0] cnt_q;

  logic accept;
  logic in_flight;
  logic timeout_hit;
  logic rsp_capture;
  logic timeout_resp;

  // A stale rvalid arriving in the same cycle clears the block, so the request
  // is still taken that cycle.
  assign accept = (state_q == ST_IDLE) && reg_valid_i && (!stale_q || mem_rvalid_i);

  assign in_flight    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign timeout_hit  = (TimeoutCycles != 0) && in_flight && (cnt_q == CNT_LAST);
  assign rsp_capture  = (state_q == ST_WAIT) && mem_rvalid_i;
  // Grant and rvalid both take priority over an expiring counter.
  assign timeout_resp = timeout_hit && !rsp_capture &&
                        !((state_q == ST_REQ) && mem_gnt_i);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_gnt_i)        state_d = ST_WAIT;
        else if (timeout_hit) state_d = ST_RESP;
      end
      ST_WAIT: begin
        if (mem_rvalid_i)     state_d = ST_RESP;
        else if (timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (in_flight && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  // A response abandoned by a WAIT timeout may still arrive; swallow exactly one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stale_q <= 1'b0;
    end else if ((state_q == ST_WAIT) && timeout_resp) begin
      stale_q <= 1'b1;
    end else if (stale_q && mem_rvalid_i) begin
      stale_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      mem_strb_o  <= '0;
    end else if (accept) begin
      mem_req_o   <= 1'b1;
      mem_addr_o  <= reg_addr_i & ADDR_ALIGN_MASK;
      mem_we_o    <= reg_write_i;
      mem_wdata_o <= reg_wdata_i;
      mem_strb_o  <= reg_write_i ? reg_wstrb_i : '1;
    end else if ((state_q == ST_REQ) && (mem_gnt_i || timeout_hit)) begin
      mem_req_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_ready_o <= 1'b0;
      reg_rdata_o <= '0;
      reg_error_o <= 1'b0;
    end else begin
      reg_ready_o <= (state_d == ST_RESP);
      if (rsp_capture) begin
        reg_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
        reg_error_o <= mem_err_i;
      end else if (timeout_resp) begin
        reg_rdata_o <= '0;
        reg_error_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_to_mem_bridge.sv
// Directed bench for reg_to_mem_bridge: instance a uses the default timeout,
// instance b uses an 8-cycle timeout; both share the same stimulus.
module tb_reg_to_mem_bridge;

  localparam int AW = 48;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic          reg_valid;
  logic          reg_write;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [SW-1:0] reg_wstrb;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;

  logic          a_ready, a_error, a_req, a_we;
  logic [DW-1:0] a_rdata, a_wdata;
  logic [AW-1:0] a_addr;
  logic [SW-1:0] a_strb;

  logic          b_ready, b_error, b_req, b_we;
  logic [DW-1:0] b_rdata, b_wdata;
  logic [AW-1:0] b_addr;
  logic [SW-1:0] b_strb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_to_mem_bridge #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(256)) u_dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .reg_valid_i  (reg_valid),
    .reg_write_i  (reg_write),
    .reg_addr_i   (reg_addr),
    .reg_wdata_i  (reg_wdata),
    .reg_wstrb_i  (reg_wstrb),
    .reg_ready_o  (a_ready),
    .reg_rdata_o  (a_rdata),
    .reg_error_o  (a_error),
    .mem_req_o    (a_req),
    .mem_gnt_i    (mem_gnt),
    .mem_addr_o   (a_addr),
    .mem_we_o     (a_we),
    .mem_wdata_o  (a_wdata),
    .mem_strb_o   (a_strb),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .mem_err_i    (mem_err)
  );

  reg_to_mem_bridge #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(8)) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .reg_valid_i  (reg_valid),
    .reg_write_i  (reg_write),
    .reg_addr_i   (reg_addr),
    .reg_wdata_i  (reg_wdata),
    .reg_wstrb_i  (reg_wstrb),
    .reg_ready_o  (b_ready),
    .reg_rdata_o  (b_rdata),
    .reg_error_o  (b_error),
    .mem_req_o    (b_req),
    .mem_gnt_i    (mem_gnt),
    .mem_addr_o   (b_addr),
    .mem_we_o     (b_we),
    .mem_wdata_o  (b_wdata),
    .mem_strb_o   (b_strb),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .mem_err_i    (mem_err)
  );

  // Outputs are sampled, and inputs changed, 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_valid  = 1'b0;
    reg_write  = 1'b0;
    reg_addr   = '0;
    reg_wdata  = '0;
    reg_wstrb  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_ready, a_error, a_rdata, a_req, a_we, a_addr, a_wdata, a_strb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a got ready=%b err=%b rdata=%h req=%b we=%b addr=%h wdata=%h strb=%h want all zero",
               a_ready, a_error, a_rdata, a_req, a_we, a_addr, a_wdata, a_strb);
    end
    checks++;
    if ({b_ready, b_error, b_rdata, b_req, b_we, b_addr, b_wdata, b_strb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b got ready=%b err=%b req=%b addr=%h want all zero",
               b_ready, b_error, b_req, b_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({a_ready, a_req} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got ready=%b req=%b want 0 0", a_ready, a_req);
    end
  endtask

  task automatic test_read_zero_wait();
    apply_reset();
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 48'h1007;
    reg_wdata = 64'h5555; reg_wstrb = 8'h03;
    step();  // cycle 1
    checks++;
    if ({a_req, a_we, a_addr, a_strb} !== {1'b1, 1'b0, 48'h1000, 8'hFF}) begin
      errors++;
      $display("FAIL read_req got req=%b we=%b addr=%h strb=%h want 1 0 1000 ff", a_req, a_we, a_addr, a_strb);
    end
    mem_gnt = 1'b1;
    step();  // cycle 2
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEADBEEF_CAFEF00D;
    checks++;
    if ({a_req, a_ready} !== 2'b00) begin
      errors++;
      $display("FAIL read_wait got req=%b ready=%b want 0 0", a_req, a_ready);
    end
    step();  // cycle 3
    mem_rvalid = 1'b0; mem_rdata = '0;
    checks++;
    if ({a_ready, a_error, a_rdata} !== {1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D}) begin
      errors++;
      $display("FAIL read_resp got ready=%b err=%b rdata=%h want 1 0 deadbeefcafef00d", a_ready, a_error, a_rdata);
    end
    reg_valid = 1'b0;
    step();  // cycle 4
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_ready_pulse got ready=%b want 0", a_ready);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 48'h0100;
    step();  // cycle 1
    mem_gnt = 1'b1;
    step();  // cycle 2
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1;
    step();  // cycle 3: response A; master immediately presents B
    mem_rvalid = 1'b0;
    checks++;
    if ({a_ready, a_rdata} !== {1'b1, 64'h1}) begin
      errors++;
      $display("FAIL b2b_first_resp got ready=%b rdata=%h want 1 1", a_ready, a_rdata);
    end
    reg_addr = 48'h0208;
    step();  // cycle 4: IDLE accepts B
    checks++;
    if ({a_ready, a_req} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle got ready=%b req=%b want 0 0", a_ready, a_req);
    end
    step();  // cycle 5
    checks++;
    if ({a_req, a_addr} !== {1'b1, 48'h0208}) begin
      errors++;
      $display("FAIL b2b_second_req got req=%b addr=%h want 1 208", a_req, a_addr);
    end
    mem_gnt = 1'b1;
    step();  // cycle 6
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h2;
    step();  // cycle 7
    mem_rvalid = 1'b0;
    checks++;
    if ({a_ready, a_rdata} !== {1'b1, 64'h2}) begin
      errors++;
      $display("FAIL b2b_second_resp got ready=%b rdata=%h want 1 2", a_ready, a_rdata);
    end
    reg_valid = 1'b0;
    step();
  endtask

  task automatic test_write_slow();
    apply_reset();
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 48'h2004;
    reg_wdata = 64'h11; reg_wstrb = 8'h0F;
    for (int i = 0; i < 6; i++) begin
      step();  // cycles 1..6
      checks++;
      if ({a_req, a_we, a_addr, a_wdata, a_strb} !== {1'b1, 1'b1, 48'h2000, 64'h11, 8'h0F}) begin
        errors++;
        $display("FAIL write_req_hold[%0d] got req=%b we=%b addr=%h wdata=%h strb=%h want 1 1 2000 11 0f",
                 i, a_req, a_we, a_addr, a_wdata, a_strb);
      end
      mem_gnt = (i == 5);
    end
    step();  // cycle 7
    mem_gnt = 1'b0;
    checks++;
    if (a_req !== 1'b0) begin
      errors++;
      $display("FAIL write_req_drop got req=%b want 0", a_req);
    end
    step();  // cycle 8
    step();  // cycle 9
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_early_ready got ready=%b want 0", a_ready);
    end
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF0000_FFFF0000;
    step();  // cycle 10
    mem_rvalid = 1'b0; mem_rdata = '0;
    checks++;
    if ({a_ready, a_error, a_rdata} !== {1'b1, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL write_resp got ready=%b err=%b rdata=%h want 1 0 0", a_ready, a_error, a_rdata);
    end
    reg_valid = 1'b0;
    step();
  endtask

  task automatic test_mem_error();
    apply_reset();
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 48'h0020;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 64'h77;
    step();
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    checks++;
    if ({a_ready, a_error, a_rdata} !== {1'b1, 1'b1, 64'h77}) begin
      errors++;
      $display("FAIL mem_error_resp got ready=%b err=%b rdata=%h want 1 1 77", a_ready, a_error, a_rdata);
    end
    reg_valid = 1'b0;
    step();
  endtask

  task automatic test_timeout_req();
    apply_reset();
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 48'h3000;
    for (int i = 1; i <= 8; i++) begin
      step();  // cycles 1..8 in REQ, no grant
      checks++;
      if ({b_req, b_ready} !== 2'b10) begin
        errors++;
        $display("FAIL timeout_req_hold[%0d] got req=%b ready=%b want 1 0", i, b_req, b_ready);
      end
    end
    step();  // cycle 9
    checks++;
    if ({b_ready, b_error, b_rdata, b_req} !== {1'b1, 1'b1, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_req_resp got ready=%b err=%b rdata=%h req=%b want 1 1 0 0",
               b_ready, b_error, b_rdata, b_req);
    end
    reg_valid = 1'b0;
    step();
    checks++;
    if ({b_ready, b_req} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_req_after got ready=%b req=%b want 0 0", b_ready, b_req);
    end
  endtask

  task automatic test_timeout_wait_stale();
    apply_reset();
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 48'h3000;
    step();  // cycle 1
    checks++;
    if (b_req !== 1'b1) begin
      errors++;
      $display("FAIL stale_first_req got req=%b want 1", b_req);
    end
    mem_gnt = 1'b1;
    step();  // cycle 2
    mem_gnt = 1'b0;
    for (int c = 3; c <= 8; c++) step();
    checks++;
    if (b_ready !== 1'b0) begin
      errors++;
      $display("FAIL stale_early_ready got ready=%b want 0", b_ready);
    end
    step();  // cycle 9
    checks++;
    if ({b_ready, b_error, b_rdata} !== {1'b1, 1'b1, 64'h0}) begin
      errors++;
      $display("FAIL stale_timeout_resp got ready=%b err=%b rdata=%h want 1 1 0", b_ready, b_error, b_rdata);
    end
    reg_addr = 48'h400B;  // second request, pending from cycle 10
    for (int c = 10; c <= 20; c++) begin
      step();
      checks++;
      if ({b_req, b_ready} !== 2'b00) begin
        errors++;
        $display("FAIL stale_blocked[%0d] got req=%b ready=%b want 0 0", c, b_req, b_ready);
      end
    end
    step();  // cycle 21: late response arrives with the request still valid
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    step();  // cycle 22
    mem_rvalid = 1'b0; mem_rdata = '0;
    checks++;
    if ({b_req, b_ready, b_addr, b_strb} !== {1'b1, 1'b0, 48'h4008, 8'hFF}) begin
      errors++;
      $display("FAIL stale_second_req got req=%b ready=%b addr=%h strb=%h want 1 0 4008 ff",
               b_req, b_ready, b_addr, b_strb);
    end
    mem_gnt = 1'b1;
    step();  // cycle 23
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h01234567_89ABCDEF;
    step();  // cycle 24
    mem_rvalid = 1'b0; mem_rdata = '0;
    checks++;
    if ({b_ready, b_error, b_rdata} !== {1'b1, 1'b0, 64'h01234567_89ABCDEF}) begin
      errors++;
      $display("FAIL stale_second_resp got ready=%b err=%b rdata=%h want 1 0 0123456789abcdef",
               b_ready, b_error, b_rdata);
    end
    reg_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 48'h5000;
    reg_wdata = 64'hAA; reg_wstrb = 8'h01;
    step();  // cycle 1
    checks++;
    if ({a_req, a_we, a_addr, a_wdata, a_strb} !== {1'b1, 1'b1, 48'h5000, 64'hAA, 8'h01}) begin
      errors++;
      $display("FAIL rst_mid_req got req=%b we=%b addr=%h wdata=%h strb=%h want 1 1 5000 aa 01",
               a_req, a_we, a_addr, a_wdata, a_strb);
    end
    mem_gnt = 1'b1;
    step();  // cycle 2: WAIT
    mem_gnt = 1'b0;
    step();  // cycle 3: still WAIT
    #2 rst_n = 1'b0;
    reg_valid = 1'b0;
    #1;
    checks++;
    if ({a_ready, a_error, a_rdata, a_req, a_we, a_addr, a_wdata, a_strb} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got ready=%b err=%b req=%b we=%b addr=%h wdata=%h strb=%h want all zero",
               a_ready, a_error, a_req, a_we, a_addr, a_wdata, a_strb);
    end
    #1 rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    checks++;
    if ({a_ready, a_req} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_late_rvalid got ready=%b req=%b want 0 0", a_ready, a_req);
    end
    reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 48'h6010;
    step();
    checks++;
    if ({a_req, a_addr} !== {1'b1, 48'h6010}) begin
      errors++;
      $display("FAIL rst_mid_next_req got req=%b addr=%h want 1 6010", a_req, a_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h42;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    checks++;
    if ({a_ready, a_error, a_rdata} !== {1'b1, 1'b0, 64'h42}) begin
      errors++;
      $display("FAIL rst_mid_next_resp got ready=%b err=%b rdata=%h want 1 0 42", a_ready, a_error, a_rdata);
    end
    reg_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_back_to_back();
    test_write_slow();
    test_mem_error();
    test_timeout_req();
    test_timeout_wait_stale();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
